pll_dvfs_seq: RTL and testbench

//  Serialises per-core PLL frequency changes (DVFS) for the SoC clock controller.
//  NUM_CORE requesters each ask for a new PLL feedback divider. Changes are applied
//  one at a time in round-robin order using a gate -> program -> relock -> ungate

---
 rtl/pll_dvfs_seq.sv | 177 +++++++++++++++++
 tb/tb_pll_dvfs_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_dvfs_seq.sv
// Round-robin DVFS sequencer that runs gate -> program -> relock -> ungate on one core PLL at a time.
// Optional thermal capping of the applied divider is enabled with `define PLL_DVFS_THERMAL_CAP_EN.
module pll_dvfs_seq #(
  parameter int NUM_CORE          = 4,
  parameter int FB_DIV_WIDTH      = 12,
  parameter int TEMP_SENSOR_WIDTH = 10,
  parameter int RESET_FB_DIV      = 64,
  parameter int GATE_CYCLES       = 8,
  parameter int LOCK_TIMEOUT      = 1024,
  parameter int TEMP_LIMIT        = 900,
  parameter int FB_DIV_CAP        = 32
) (
  input  logic                                  clk_i,
  input  logic                                  arst_ni,
  input  logic [NUM_CORE-1:0]                   req_valid_i,
  input  logic [NUM_CORE*FB_DIV_WIDTH-1:0]      req_fb_div_i,
  output logic [NUM_CORE-1:0]                   req_ready_o,
  output logic [NUM_CORE*FB_DIV_WIDTH-1:0]      core_pll_fb_div_o,
  input  logic [NUM_CORE-1:0]                   core_pll_locked_i,
  output logic [NUM_CORE-1:0]                   core_clk_en_o,
  input  logic [NUM_CORE*TEMP_SENSOR_WIDTH-1:0] core_temp_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [$clog2(NUM_CORE)-1:0]           done_id_o,
  output logic                                  done_err_o
);

  localparam int ID_W        = $clog2(NUM_CORE);
  localparam int CNT_MAX     = (LOCK_TIMEOUT > GATE_CYCLES) ? LOCK_TIMEOUT : GATE_CYCLES;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int LOCK_IGNORE = 4;

  typedef enum logic [2:0] {ST_IDLE, ST_GATE, ST_PROG, ST_LOCK, ST_UNGATE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         cur_id;
  logic [FB_DIV_WIDTH-1:0] cur_fb;
  logic [FB_DIV_WIDTH-1:0] fb_div_q [NUM_CORE];
  logic [FB_DIV_WIDTH-1:0] req_fb   [NUM_CORE];
  logic [NUM_CORE-1:0]     lock_p0, lock_p1;
  logic                    grant_vld;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W-1:0]         scan_id;
  logic [FB_DIV_WIDTH-1:0] grant_fb;

  for (genvar c = 0; c < NUM_CORE; c++) begin : g_core
    assign req_fb[c] = req_fb_div_i[c*FB_DIV_WIDTH +: FB_DIV_WIDTH];
    assign core_pll_fb_div_o[c*FB_DIV_WIDTH +: FB_DIV_WIDTH] = fb_div_q[c];
  end

`ifdef PLL_DVFS_THERMAL_CAP_EN
  logic [TEMP_SENSOR_WIDTH-1:0] temp [NUM_CORE];

  for (genvar c = 0; c < NUM_CORE; c++) begin : g_temp
    assign temp[c] = core_temp_i[c*TEMP_SENSOR_WIDTH +: TEMP_SENSOR_WIDTH];
  end

  function automatic logic [FB_DIV_WIDTH-1:0] cap_fb_div(input logic [FB_DIV_WIDTH-1:0]      req,
                                                        input logic [TEMP_SENSOR_WIDTH-1:0] t);
    if (t >= TEMP_SENSOR_WIDTH'(TEMP_LIMIT) && req > FB_DIV_WIDTH'(FB_DIV_CAP))
      return FB_DIV_WIDTH'(FB_DIV_CAP);
    return req;
  endfunction

  assign grant_fb = cap_fb_div(req_fb[grant_id], temp[grant_id]);
`else
  logic unused_temp;

  assign grant_fb    = req_fb[grant_id];
  assign unused_temp = (^core_temp_i) ^ (TEMP_LIMIT != FB_DIV_CAP);
`endif

  // Round-robin scan from rr_ptr; held off during the done pulse so the next grant lands after it.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    if (state == ST_IDLE && !done_o) begin
      for (int i = 0; i < NUM_CORE; i++) begin
        scan_id = ID_W'((int'(rr_ptr) + i) % NUM_CORE);
        if (!grant_vld && req_valid_i[scan_id]) begin
          grant_vld = 1'b1;
          grant_id  = scan_id;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_vld) req_ready_o[grant_id] = 1'b1;
  end

  assign busy_o = (state != ST_IDLE);

  // Lock synchroniser stage boundary: p0 may go metastable, p1 is the usable level.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_p0 <= '0;
      lock_p1 <= '0;
    end else begin
      lock_p0 <= core_pll_locked_i;
      lock_p1 <= lock_p0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      cur_id        <= '0;
      cur_fb        <= '0;
      done_o        <= 1'b0;
      done_err_o    <= 1'b0;
      done_id_o     <= '0;
      core_clk_en_o <= '1;
      for (int c = 0; c < NUM_CORE; c++) fb_div_q[c] <= FB_DIV_WIDTH'(RESET_FB_DIV);
    end else begin
      done_o     <= 1'b0;
      done_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            rr_ptr    <= ID_W'((int'(grant_id) + 1) % NUM_CORE);
            cur_id    <= grant_id;
            cur_fb    <= grant_fb;
            done_id_o <= grant_id;
            cnt       <= '0;
            if (grant_fb == '0) begin
              done_o     <= 1'b1;
              done_err_o <= 1'b1;
            end else if (grant_fb == fb_div_q[grant_id]) begin
              done_o <= 1'b1;
            end else begin
              state                   <= ST_GATE;
              core_clk_en_o[grant_id] <= 1'b0;
            end
          end
        end
        ST_GATE: begin
          if (cnt == CNT_W'(GATE_CYCLES - 1)) begin
            state <= ST_PROG;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PROG: begin
          fb_div_q[cur_id] <= cur_fb;
          state            <= ST_LOCK;
          cnt              <= '0;
        end
        ST_LOCK: begin
          cnt <= cnt + 1'b1;
          // Early synced lock samples may still reflect the old frequency, so they are skipped.
          if (cnt >= CNT_W'(LOCK_IGNORE) && lock_p1[cur_id]) begin
            state                 <= ST_UNGATE;
            core_clk_en_o[cur_id] <= 1'b1;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state      <= ST_IDLE;
            done_o     <= 1'b1;
            done_err_o <= 1'b1;
          end
        end
        ST_UNGATE: begin
          state  <= ST_IDLE;
          done_o <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_dvfs_seq.sv
// Directed bench for pll_dvfs_seq: reset, full sequence timing, round-robin order,
// lock timeout, no-op / zero requests, thermal cap (when PLL_DVFS_THERMAL_CAP_EN) and reset abort.
module tb_pll_dvfs_seq;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [3:0]  req_valid_i;
  logic [47:0] req_fb_div_i;
  logic [3:0]  req_ready_o;
  logic [47:0] core_pll_fb_div_o;
  logic [3:0]  core_pll_locked_i;
  logic [3:0]  core_clk_en_o;
  logic [39:0] core_temp_i;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  done_id_o;
  logic        done_err_o;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk_i = ~clk_i;

  pll_dvfs_seq dut (
    .clk_i             (clk_i),
    .arst_ni           (arst_ni),
    .req_valid_i       (req_valid_i),
    .req_fb_div_i      (req_fb_div_i),
    .req_ready_o       (req_ready_o),
    .core_pll_fb_div_o (core_pll_fb_div_o),
    .core_pll_locked_i (core_pll_locked_i),
    .core_clk_en_o     (core_clk_en_o),
    .core_temp_i       (core_temp_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .done_id_o         (done_id_o),
    .done_err_o        (done_err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [11:0] get_fb(input int c);
    return core_pll_fb_div_o[c*12 +: 12];
  endfunction

  task automatic set_fb(input int c, input logic [11:0] v);
    req_fb_div_i[c*12 +: 12] = v;
  endtask

  task automatic wait_busy();
    int k = 0;
    while (!busy_o && k < 8) begin
      tick();
      k++;
    end
    check("busy_seen", busy_o, 1'b1);
  endtask

  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!done_o && cnt < limit);
    check("done_seen", done_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_ni           = 1'b0;
    req_valid_i       = '0;
    req_fb_div_i      = '0;
    core_pll_locked_i = '0;
    core_temp_i       = '0;

    // Reset values
    repeat (3) tick();
    check("rst_fb",     core_pll_fb_div_o, 48'h040040040040);
    check("rst_clk_en", core_clk_en_o, 4'hf);
    check("rst_busy",   busy_o, 1'b0);
    check("rst_ready",  req_ready_o, 4'h0);
    check("rst_done",   {done_o, done_err_o, done_id_o}, 4'h0);
    arst_ni = 1'b1;
    tick();
    check("idle_busy",  busy_o, 1'b0);
    check("idle_ready", req_ready_o, 4'h0);

    // Core1 -> 100, lock rises 3 cycles after PROG
    set_fb(1, 12'd100);
    req_valid_i = 4'b0010;
    #1;
    check("c1_ready", req_ready_o, 4'b0010);
    tick();                                    // grant edge E0
    check("c1_busy",   busy_o, 1'b1);
    check("c1_gated",  core_clk_en_o, 4'b1101);
    check("c1_rdy_lo", req_ready_o, 4'h0);
    req_valid_i = '0;
    repeat (7) tick();                         // E7
    check("c1_gate_end_en", core_clk_en_o, 4'b1101);
    check("c1_gate_end_fb", get_fb(1), 12'd64);
    tick();                                    // E8 PROG
    check("c1_prog_fb", get_fb(1), 12'd64);
    tick();                                    // E9
    check("c1_new_fb", get_fb(1), 12'd100);
    check("c1_other_fb", core_pll_fb_div_o, 48'h040040064040);
    repeat (2) tick();                         // E11
    core_pll_locked_i[1] = 1'b1;
    repeat (2) tick();                         // E13
    check("c1_still_lock", core_clk_en_o, 4'b1101);
    tick();                                    // E14 UNGATE
    check("c1_ungate_en",   core_clk_en_o, 4'hf);
    check("c1_ungate_done", done_o, 1'b0);
    tick();                                    // E15
    check("c1_done", {done_o, done_err_o, done_id_o}, {1'b1, 1'b0, 2'd1});
    check("c1_done_busy", busy_o, 1'b0);
    tick();
    check("c1_done_pulse", done_o, 1'b0);

    // Request equal to current value: no gating, done next cycle
    set_fb(0, 12'd64);
    req_valid_i = 4'b0001;
    #1;
    check("eq_ready", req_ready_o, 4'b0001);
    tick();
    check("eq_done",   {done_o, done_err_o, done_id_o}, {1'b1, 1'b0, 2'd0});
    check("eq_clk_en", core_clk_en_o, 4'hf);
    check("eq_busy",   busy_o, 1'b0);
    check("eq_hold_off", req_ready_o, 4'h0);
    req_valid_i = '0;
    tick();
    check("eq_pulse", done_o, 1'b0);

    // Zero request: rejected, no output change
    set_fb(2, 12'd0);
    req_valid_i = 4'b0100;
    #1;
    check("zero_ready", req_ready_o, 4'b0100);
    tick();
    check("zero_done",   {done_o, done_err_o, done_id_o}, {1'b1, 1'b1, 2'd2});
    check("zero_fb",     core_pll_fb_div_o, 48'h040040064040);
    check("zero_clk_en", core_clk_en_o, 4'hf);
    req_valid_i = '0;
    tick();

    // All four request from reset: grants 0,1,2,3
    arst_ni = 1'b0;
    #1;
    check("arst_fb",     core_pll_fb_div_o, 48'h040040040040);
    check("arst_clk_en", core_clk_en_o, 4'hf);
    core_pll_locked_i = 4'hf;
    repeat (2) tick();
    arst_ni = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) set_fb(c, 12'(200 + c));
    req_valid_i = 4'hf;
    #1;
    check("rr_first_ready", req_ready_o, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      wait_busy();
      check($sformatf("rr_gate_%0d", k), core_clk_en_o, 4'hf & ~(4'b0001 << k));
      wait_done(40, n);
      check($sformatf("rr_lat_%0d", k), n, 15);
      check($sformatf("rr_id_%0d", k), {done_err_o, done_id_o}, {1'b0, 2'(k)});
      check($sformatf("rr_fb_%0d", k), get_fb(k), 12'(200 + k));
      check($sformatf("rr_en_%0d", k), core_clk_en_o, 4'hf);
      req_valid_i[k] = 1'b0;
    end
    tick();
    set_fb(0, 12'd300);
    set_fb(3, 12'd303);
    req_valid_i = 4'b1001;
    #1;
    check("rr_wrap_ready", req_ready_o, 4'b0001);
    wait_busy();
    wait_done(40, n);
    check("rr_wrap_id0", done_id_o, 2'd0);
    check("rr_wrap_fb0", get_fb(0), 12'd300);
    req_valid_i[0] = 1'b0;
    wait_busy();
    wait_done(40, n);
    check("rr_wrap_id3", done_id_o, 2'd3);
    check("rr_wrap_fb3", get_fb(3), 12'd303);
    req_valid_i = '0;
    tick();

    // Lock never arrives on core2: timeout after 1024 LOCK cycles
    core_pll_locked_i = 4'b1011;
    set_fb(2, 12'd500);
    req_valid_i = 4'b0100;
    wait_busy();
    req_valid_i = '0;
    wait_done(1100, n);
    check("to_latency", n, 1033);
    check("to_done",    {done_err_o, done_id_o}, {1'b1, 2'd2});
    check("to_clk_en",  core_clk_en_o, 4'b1011);
    check("to_fb",      get_fb(2), 12'd500);
    core_pll_locked_i = 4'hf;
    tick();

`ifdef PLL_DVFS_THERMAL_CAP_EN
    // Hot core is capped, cool core is not
    core_temp_i[1*10 +: 10] = 10'd950;
    set_fb(1, 12'd100);
    req_valid_i = 4'b0010;
    wait_busy();
    req_valid_i = '0;
    wait_done(40, n);
    check("hot_fb", get_fb(1), 12'd32);
    tick();
    core_temp_i[1*10 +: 10] = 10'd800;
    req_valid_i = 4'b0010;
    wait_busy();
    req_valid_i = '0;
    wait_done(40, n);
    check("cool_fb", get_fb(1), 12'd100);
    tick();
`endif

    // Reset during LOCK aborts the sequence
    core_pll_locked_i[0] = 1'b0;
    set_fb(0, 12'd77);
    req_valid_i = 4'b0001;
    wait_busy();
    req_valid_i = '0;
    repeat (12) tick();
    check("ab_gated", core_clk_en_o[0], 1'b0);
    check("ab_fb",    get_fb(0), 12'd77);
    check("ab_busy",  busy_o, 1'b1);
    arst_ni = 1'b0;
    #1;
    check("ab_clk_en", core_clk_en_o, 4'hf);
    check("ab_fb_rst", core_pll_fb_div_o, 48'h040040040040);
    check("ab_idle",   {busy_o, done_o, done_err_o}, 3'b000);
    tick();
    arst_ni = 1'b1;
    tick();
    set_fb(1, 12'd300);
    req_valid_i = 4'b0010;
    #1;
    check("ab_ready", req_ready_o, 4'b0010);
    req_valid_i = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
